// File: rtl/cskipa_multicycle_ctrl_if.sv
// Operand/result handshake bundle for the time-multiplexed carry-skip adder.
// The slave modport is the adder's view. The master modport is the producer/consumer view.
interface cskipa_multicycle_ctrl_if #(
  parameter int WIDTH = 80
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             i_cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_cin, i_ready,
    output o_ready, o_valid, sum, cout, ovf, busy
  );

  modport master (
    output i_valid, i_add_term1, i_add_term2, i_cin, i_ready,
    input  o_ready, o_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/cskipa_multicycle_ctrl.sv
// Wide adder built from one shared SLICE-bit carry-skip slice, reused one slice per clock.
// The carry is registered between passes, and the LSB slice is computed first.
module cskipa_multicycle_ctrl #(
  parameter int WIDTH = 80,
  parameter int SLICE = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  cskipa_multicycle_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int NGROUP = SLICE / 4;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] a_slice, b_slice, slice_sum;
  logic             slice_cout, slice_c_msb;

  assign a_slice = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_slice = b_q[int'(cnt_q)*SLICE +: SLICE];

  // Ripple inside each 4-bit group. When every propagate bit of the group is set,
  // the group carry-in skips straight to the group carry-out.
  always_comb begin
    logic c, gcin, gp, rc, p, gen;
    int   idx;
    slice_sum   = '0;
    slice_c_msb = 1'b0;
    c           = carry_q;
    gcin        = 1'b0;
    gp          = 1'b0;
    rc          = 1'b0;
    p           = 1'b0;
    gen         = 1'b0;
    idx         = 0;
    for (int g = 0; g < NGROUP; g++) begin
      gcin = c;
      gp   = 1'b1;
      rc   = c;
      for (int bit_i = 0; bit_i < 4; bit_i++) begin
        idx            = g * 4 + bit_i;
        p              = a_slice[idx] ^ b_slice[idx];
        gen            = a_slice[idx] & b_slice[idx];
        slice_sum[idx] = p ^ rc;
        if (idx == SLICE - 1) slice_c_msb = rc;
        rc             = gen | (p & rc);
        gp             = gp & p;
      end
      c = gp ? gcin : rc;
    end
    slice_cout = c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_add_term1;
          b_d     = bus.i_add_term2;
          carry_d = bus.i_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q)*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        if (cnt_q == CW'(NSLICE - 1)) begin
          cout_d  = slice_cout;
          ovf_d   = slice_cout ^ slice_c_msb;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.busy    = (state_q == RUN) || (state_q == DONE);
  assign bus.sum     = sum_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;
endmodule

// File: doc/cskipa_multicycle_ctrl.md
Name: cskipa_multicycle_ctrl

Overview:
- Sequencer that performs a wide (WIDTH-bit) addition by time-multiplexing one SLICE-bit carry-skip adder slice, one slice per clock, LSB slice first.
- Registered carry is chained between slices.
- Valid/ready handshake on both the operand side and the result side.
- Sits between operand producers and consumers when a full-width carry-skip adder is too large; trades latency for area.

Parameters:
- WIDTH, 80, total operand/result width; must be an integer multiple of SLICE.
- SLICE, 20, width of the shared adder slice; must be a multiple of 4, matching the 4-bit skip-group structure.
- NSLICE, WIDTH/SLICE, number of slice passes; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_valid  in  1  operand request valid.
- o_ready  out  1  block can accept operands.
- i_add_term1  in  WIDTH  operand A.
- i_add_term2  in  WIDTH  operand B.
- i_cin  in  1  carry into slice 0.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- sum  out  WIDTH  A+B+cin, modulo 2^WIDTH.
- cout  out  1  carry out of MSB.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n=0 at a rising edge, any state):
  - State goes to IDLE.
  - o_valid, sum, cout, ovf, busy, slice counter and carry register all clear to 0.
  - o_ready=1 after reset completes.
  - A reset mid-RUN or mid-DONE discards the operation; no partial result is presented.
- States: IDLE, RUN, DONE. o_ready=1 only in IDLE; no overlap of operations.
- IDLE:
  - On i_valid&&o_ready, latch A, B and i_cin into the carry register.
  - Clear the slice counter and go to RUN.
  - i_valid with o_ready=0 is ignored; the producer must hold.
- RUN, slice counter k = 0..NSLICE-1:
  - Each cycle, slice k computes A[k*SLICE+:SLICE] + B[k*SLICE+:SLICE] + carry.
  - Slice result is written to sum[k*SLICE+:SLICE]; the carry register takes the slice carry-out.
  - When k=NSLICE-1, also capture cout and ovf (the MSB carry-in is taken from within the final slice), then go to DONE.
  - The counter does not wrap within an operation.
- DONE:
  - o_valid=1; sum, cout and ovf are held stable.
  - On i_ready=1, go to IDLE and drop o_valid the next cycle.
  - If i_ready is held high continuously, o_valid is high for exactly 1 cycle.
- Latency:
  - Accept edge at cycle T; o_valid is first high in cycle T+NSLICE+1.
  - Throughput is one operation per NSLICE+2 cycles when the consumer is always ready.
- Intermediate visibility:
  - sum bits for slices not yet computed hold the previous operation's value during RUN.
  - Consumers must sample only when o_valid=1.
- Slice adder:
  - Carry-skip structure in 4-bit groups with a real cin input (cin is not tied off).
  - The skip path is active when all propagate bits of a group are 1.
- Width rules:
  - All arithmetic is unsigned modulo 2^WIDTH.
  - cout is the bit WIDTH of the true sum.
- Operand side: i_add_term1, i_add_term2 and i_cin are sampled only on the accept edge. Changes afterwards have no effect.

Test Plan:
- Reset/idle check: after reset, o_ready=1, o_valid=0, sum=0, cout=0, ovf=0, busy=0.
- Basic add, WIDTH=80:
  - Stimulus: A=0x0000_0000_0000_0000_0001, B=0x0000_0000_0000_0000_0002, cin=0.
  - Response: sum=0x...0003, cout=0, ovf=0, o_valid high exactly 5 cycles after accept.
- Full carry ripple across all slices:
  - Stimulus: A=0xFFFF_FFFF_FFFF_FFFF_FFFF, B=0, cin=1.
  - Response: sum=0, cout=1, ovf=0.
  - Also confirm the carry crosses each slice boundary: probe the carry register =1 after each RUN cycle.
- Signed overflow:
  - Stimulus: A=0x7FFF_FFFF_FFFF_FFFF_FFFF, B=1, cin=0.
  - Response: sum=0x8000_0000_0000_0000_0000, cout=0, ovf=1.
- Backpressure and handshake:
  - Hold i_ready=0 for 10 cycles in DONE: o_valid and sum stay stable, and o_ready=0 throughout.
  - A second i_valid presented during RUN/DONE is not accepted until IDLE.
  - Back-to-back operations with i_ready=1 are spaced 6 cycles apart.
- Reset mid-operation:
  - Assert rst_n=0 for one edge in RUN at k=2.
  - Response: next cycle IDLE, o_valid=0, sum=0.
  - A new operation 0x12345 + 0x54321 then completes correctly with sum=0x66666.
